alu_z_stage: RTL and testbench

ALU_Z_STAGE -- requirements
Module: alu_z_stage

---
 rtl/alu_pkg.sv | 64 ++++++
 rtl/alu_z_stage_if.sv | 16 +
 rtl/seq_muldiv_core.sv | 91 +++++++++
 rtl/alu_z_stage.sv | 81 ++++++++
 tb/tb_alu_z_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, op encodings and the per-iteration
// Booth / restoring-division step functions used by the sequential core.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ITERS  = 32;
  localparam int unsigned CNT_W  = $clog2(ITERS);

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_SHR  = 4'd4,
    OP_SHRA = 4'd5,
    OP_SHL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_ROL  = 4'd8,
    OP_NEG  = 4'd9,
    OP_NOT  = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIV  = 4'd12
  } op_e;

  // hi is one bit wider so Booth accumulation survives a -2^31 multiplicand
  typedef struct packed {
    logic [DATA_W:0]   hi;
    logic [DATA_W-1:0] lo;
    logic              q;
  } work_t;

  function automatic work_t booth_step(input work_t w, input logic [DATA_W-1:0] a);
    work_t           r;
    logic [DATA_W:0] acc;
    case ({w.lo[0], w.q})
      2'b01:   acc = w.hi + {a[DATA_W-1], a};
      2'b10:   acc = w.hi - {a[DATA_W-1], a};
      default: acc = w.hi;
    endcase
    r.hi = {acc[DATA_W], acc[DATA_W:1]};
    r.lo = {acc[0], w.lo[DATA_W-1:1]};
    r.q  = w.lo[0];
    return r;
  endfunction

  function automatic work_t div_step(input work_t w, input logic [DATA_W-1:0] d);
    work_t           r;
    logic [DATA_W:0] rem;
    rem  = {w.hi[DATA_W-1:0], w.lo[DATA_W-1]};
    r.lo = {w.lo[DATA_W-2:0], 1'b0};
    r.q  = 1'b0;
    if (rem >= {1'b0, d}) begin
      rem     = rem - {1'b0, d};
      r.lo[0] = 1'b1;
    end
    r.hi = rem;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/alu_z_stage_if.sv
// Bus-side signal bundle of the ALU/Z stage.
interface alu_z_stage_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] bus_in;
  logic              y_in;
  logic [3:0]        op;
  logic              start;
  logic [DATA_W-1:0] zhi;
  logic [DATA_W-1:0] zlo;
  logic              busy;
  logic              done;

  modport master (output bus_in, y_in, op, start, input zhi, zlo, busy, done);
  modport slave  (input bus_in, y_in, op, start, output zhi, zlo, busy, done);
endinterface

// File: rtl/seq_muldiv_core.sv
// Sequential signed multiplier (radix-2 Booth) / restoring divider, one
// iteration per clock; result valid while done is high.
module seq_muldiv_core
  import alu_pkg::*;
(
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                is_div,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt;
  work_t             w, w_src, w_next;
  logic [DATA_W-1:0] a_r, d_r, opnd, quo, rem;
  logic              div_r, neg_q, neg_r, bz_r, div_sel;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start) state_n = S_RUN;
      S_RUN:    if (cnt == CNT_W'(ITERS - 1)) state_n = S_FINISH;
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Iteration 0 runs on the capture edge from the raw operands, so the
  // 32nd iteration lands one edge before FINISH hands the result over.
  always_comb begin
    if (state == S_IDLE) begin
      div_sel  = is_div;
      w_src    = '0;
      w_src.lo = is_div ? mag(a) : b;
      opnd     = is_div ? mag(b) : a;
    end else begin
      div_sel = div_r;
      w_src   = w;
      opnd    = div_r ? d_r : a_r;
    end
    w_next = div_sel ? div_step(w_src, opnd) : booth_step(w_src, opnd);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
      cnt   <= '0;
      w     <= '0;
      a_r   <= '0;
      d_r   <= '0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      bz_r  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        w     <= w_next;
        cnt   <= CNT_W'(1);
        a_r   <= a;
        d_r   <= mag(b);
        div_r <= is_div;
        neg_q <= a[DATA_W-1] ^ b[DATA_W-1];
        neg_r <= a[DATA_W-1];
        bz_r  <= (b == '0);
      end else if (state == S_RUN) begin
        w   <= w_next;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    quo = neg_q ? -w.lo : w.lo;
    rem = neg_r ? -w.hi[DATA_W-1:0] : w.hi[DATA_W-1:0];
    if (!div_r)    result = {w.hi[DATA_W-1:0], w.lo};
    else if (bz_r) result = {a_r, {DATA_W{1'b1}}};
    else           result = {rem, quo};
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_FINISH);

endmodule

// File: rtl/alu_z_stage.sv
// ALU with Y operand register and 64-bit Z result register; logic/shift ops
// complete in one cycle, MUL/DIV go through seq_muldiv_core.
module alu_z_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = alu_pkg::DATA_W
) (
  input  logic         clock,
  input  logic         clear,
  alu_z_stage_if.slave zif
);

  logic [DATA_W-1:0]   y, opb, res, zhi_r, zlo_r;
  logic [4:0]          amt;
  logic [2*DATA_W-1:0] dbl_r, dbl_l, core_res;
  logic                core_busy, core_done, done_r, accept, is_seq, is_div;

  assign accept = zif.start && !core_busy;
  assign is_div = (zif.op == OP_DIV);
  assign is_seq = (zif.op == OP_MUL) || is_div;

  always_comb begin
    opb   = zif.bus_in;
    amt   = opb[4:0];
    dbl_r = {y, y} >> amt;
    dbl_l = {y, y} << amt;
    res   = '0;
    case (zif.op)
      OP_AND:  res = y & opb;
      OP_OR:   res = y | opb;
      OP_ADD:  res = y + opb;
      OP_SUB:  res = y - opb;
      OP_SHR:  res = y >> amt;
      OP_SHRA: res = $signed(y) >>> amt;
      OP_SHL:  res = y << amt;
      OP_ROR:  res = dbl_r[DATA_W-1:0];
      OP_ROL:  res = dbl_l[2*DATA_W-1:DATA_W];
      OP_NEG:  res = -y;
      OP_NOT:  res = ~y;
      default: res = '0;
    endcase
  end

  seq_muldiv_core u_core (
    .clock  (clock),
    .clear  (clear),
    .start  (accept && is_seq),
    .is_div (is_div),
    .a      (y),
    .b      (opb),
    .busy   (core_busy),
    .done   (core_done),
    .result (core_res)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      y      <= '0;
      zhi_r  <= '0;
      zlo_r  <= '0;
      done_r <= 1'b0;
    end else begin
      if (zif.y_in) y <= zif.bus_in;
      done_r <= 1'b0;
      if (core_done) begin
        {zhi_r, zlo_r} <= core_res;
        done_r         <= 1'b1;
      end else if (accept && !is_seq) begin
        zhi_r  <= '0;
        zlo_r  <= res;
        done_r <= 1'b1;
      end
    end
  end

  assign zif.zhi  = zhi_r;
  assign zif.zlo  = zlo_r;
  assign zif.busy = core_busy;
  assign zif.done = done_r;

endmodule

// File: tb/tb_alu_z_stage.sv
// Directed bench for alu_z_stage: cycle-level behavioural model compared every
// cycle, plus hand-computed result checks.
module tb_alu_z_stage;

  logic        clock = 1'b0;
  logic        clear;
  int unsigned checks = 0;
  int unsigned errors = 0;

  alu_z_stage_if zif();

  alu_z_stage #(.DATA_W(32)) dut (
    .clock (clock),
    .clear (clear),
    .zif   (zif)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results straight from the arithmetic definitions.
  function automatic logic [63:0] model_op(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] o);
    int unsigned n;
    logic [31:0] r;
    longint      sa, sb, q, rm;
    n  = b[4:0];
    r  = a;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      4'd0:  return {32'h0, a & b};
      4'd1:  return {32'h0, a | b};
      4'd2:  return {32'h0, a + b};
      4'd3:  return {32'h0, a - b};
      4'd4:  begin repeat (n) r = {1'b0, r[31:1]};  return {32'h0, r}; end
      4'd5:  begin repeat (n) r = {r[31], r[31:1]}; return {32'h0, r}; end
      4'd6:  begin repeat (n) r = {r[30:0], 1'b0};  return {32'h0, r}; end
      4'd7:  begin repeat (n) r = {r[0], r[31:1]};  return {32'h0, r}; end
      4'd8:  begin repeat (n) r = {r[30:0], r[31]}; return {32'h0, r}; end
      4'd9:  return {32'h0, 32'h0 - a};
      4'd10: return {32'h0, ~a};
      4'd11: return sa * sb;
      4'd12: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q  = sa / sb;
        rm = sa % sb;
        return {rm[31:0], q[31:0]};
      end
      default: return 64'h0;
    endcase
  endfunction

  logic [31:0] m_y    = '0;
  logic [31:0] m_zhi  = '0;
  logic [31:0] m_zlo  = '0;
  logic        m_done = 1'b0;
  int unsigned m_cnt  = 0;
  logic [63:0] m_pend = '0;

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      m_y <= '0; m_zhi <= '0; m_zlo <= '0; m_done <= 1'b0; m_cnt <= 0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_zhi  <= m_pend[63:32];
          m_zlo  <= m_pend[31:0];
          m_done <= 1'b1;
        end
      end else if (zif.start) begin
        if (zif.op == 4'd11 || zif.op == 4'd12) begin
          m_pend <= model_op(m_y, zif.bus_in, zif.op);
          m_cnt  <= 32;
        end else begin
          {m_zhi, m_zlo} <= model_op(m_y, zif.bus_in, zif.op);
          m_done         <= 1'b1;
        end
      end
      if (zif.y_in) m_y <= zif.bus_in;
    end
  end

  always @(negedge clock) begin
    if (clear === 1'b1) begin
      check("cmp_zhi",  zif.zhi,  m_zhi);
      check("cmp_zlo",  zif.zlo,  m_zlo);
      check("cmp_busy", zif.busy, m_cnt != 0);
      check("cmp_done", zif.done, m_done);
    end
  end

  task automatic step(input logic yi, input logic [31:0] b, input logic [3:0] o, input logic st);
    @(negedge clock);
    zif.y_in   = yi;
    zif.bus_in = b;
    zif.op     = o;
    zif.start  = st;
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] o, input logic [63:0] exp);
    step(1'b1, a, 4'd0, 1'b0);
    step(1'b0, b, o, 1'b1);
    step(1'b0, 32'h0, 4'd0, 1'b0);
    if (o == 4'd11 || o == 4'd12) begin
      repeat (32) @(posedge clock);
      #1;
    end
    check({name, "_z"}, {zif.zhi, zif.zlo}, exp);
    check({name, "_done"}, {63'h0, zif.done}, 64'h1);
  endtask

  initial begin
    clear = 1'b0;
    zif.bus_in = '0; zif.y_in = 1'b0; zif.op = '0; zif.start = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_z",    {zif.zhi, zif.zlo}, 64'h0);
    check("rst_busy", {63'h0, zif.busy}, 64'h0);
    check("rst_done", {63'h0, zif.done}, 64'h0);
    clear = 1'b1;

    run_op("and",      32'hFFFF_FFFC, 32'hFFFF_FFFD, 4'd0,  64'h0000_0000_FFFF_FFFC);
    run_op("mul_m3x7", 32'hFFFF_FFFD, 32'h0000_0007, 4'd11, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("div_m17",  32'hFFFF_FFEF, 32'h0000_0005, 4'd12, 64'hFFFF_FFFE_FFFF_FFFD);
    run_op("div_zero", 32'h0000_1234, 32'h0000_0000, 4'd12, 64'h0000_1234_FFFF_FFFF);
    run_op("or",       32'hF0F0_0000, 32'h0000_FFFF, 4'd1,  64'h0000_0000_F0F0_FFFF);
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0002, 4'd2,  64'h0000_0000_0000_0001);
    run_op("sub_wrap", 32'h0000_0000, 32'h0000_0001, 4'd3,  64'h0000_0000_FFFF_FFFF);
    run_op("shr_31",   32'h8000_0000, 32'hFFFF_FFFF, 4'd4,  64'h0000_0000_0000_0001);
    run_op("shra_4",   32'h8000_0000, 32'h0000_0004, 4'd5,  64'h0000_0000_F800_0000);
    run_op("shl_amt0", 32'h0000_0001, 32'h0000_0020, 4'd6,  64'h0000_0000_0000_0001);
    run_op("ror_1",    32'h0000_0001, 32'h0000_0001, 4'd7,  64'h0000_0000_8000_0000);
    run_op("rol_4",    32'h8000_0001, 32'h0000_0004, 4'd8,  64'h0000_0000_0000_0018);
    run_op("neg",      32'h0000_0005, 32'h0000_0000, 4'd9,  64'h0000_0000_FFFF_FFFB);
    run_op("not",      32'h0F0F_0F0F, 32'h0000_0000, 4'd10, 64'h0000_0000_F0F0_F0F0);
    run_op("undef13",  32'h1234_5678, 32'h0000_00FF, 4'd13, 64'h0);
    run_op("undef15",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 64'h0);
    run_op("mul_min",  32'h8000_0000, 32'h8000_0000, 4'd11, 64'h4000_0000_0000_0000);
    run_op("mul_maxn", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd11, 64'hFFFF_FFFF_8000_0001);
    run_op("div_ovf",  32'h8000_0000, 32'hFFFF_FFFF, 4'd12, 64'h0000_0000_8000_0000);
    run_op("div_7_m2", 32'h0000_0007, 32'hFFFF_FFFE, 4'd12, 64'h0000_0001_FFFF_FFFD);
    run_op("div_m7_2", 32'hFFFF_FFF9, 32'h0000_0002, 4'd12, 64'hFFFF_FFFF_FFFF_FFFD);

    // back-to-back single-cycle ops
    step(1'b1, 32'd10, 4'd0, 1'b0);
    step(1'b0, 32'd3,  4'd2, 1'b1);
    step(1'b0, 32'd1,  4'd3, 1'b1);
    step(1'b0, 32'd0,  4'd0, 1'b0);
    check("b2b_sub", {zif.zhi, zif.zlo}, 64'd9);

    // new start on the cycle MUL completes
    step(1'b1, 32'd6, 4'd0,  1'b0);
    step(1'b0, 32'd7, 4'd11, 1'b1);
    step(1'b0, 32'd0, 4'd0,  1'b0);
    repeat (32) @(posedge clock);
    #1;
    check("chain_mul",  {zif.zhi, zif.zlo}, 64'd42);
    check("chain_busy", {63'h0, zif.busy}, 64'h0);
    zif.bus_in = 32'd1; zif.op = 4'd2; zif.start = 1'b1;
    @(posedge clock);
    #1;
    check("chain_add", {zif.zhi, zif.zlo}, 64'd7);
    check("chain_add_done", {63'h0, zif.done}, 64'h1);

    // start while busy is ignored; Y loads while busy
    step(1'b1, 32'd100, 4'd0, 1'b0);
    step(1'b0, 32'd3,   4'd11, 1'b1);
    repeat (3) step(1'b0, 32'd0, 4'd0, 1'b0);
    step(1'b0, 32'd55,  4'd2, 1'b1);
    step(1'b1, 32'h999, 4'd0, 1'b0);
    step(1'b0, 32'd0,   4'd0, 1'b0);
    repeat (27) @(posedge clock);
    #1;
    check("busy_mul", {zif.zhi, zif.zlo}, 64'd300);
    check("busy_mul_done", {63'h0, zif.done}, 64'h1);
    step(1'b0, 32'd1, 4'd2, 1'b1);
    step(1'b0, 32'd0, 4'd0, 1'b0);
    check("y_loaded_busy", {zif.zhi, zif.zlo}, 64'h99A);

    // asynchronous clear in the middle of a MUL
    step(1'b1, 32'h11, 4'd0,  1'b0);
    step(1'b0, 32'h10, 4'd11, 1'b1);
    repeat (9) step(1'b0, 32'd0, 4'd0, 1'b0);
    step(1'b0, 32'h5A, 4'd1, 1'b1);
    #2 clear = 1'b0;
    #1;
    check("clr_z",    {zif.zhi, zif.zlo}, 64'h0);
    check("clr_busy", {63'h0, zif.busy}, 64'h0);
    check("clr_done", {63'h0, zif.done}, 64'h0);
    #1 clear = 1'b1;
    step(1'b0, 32'd0, 4'd0, 1'b0);
    check("post_clr_or", {zif.zhi, zif.zlo}, 64'h5A);
    run_op("post_clr_and", 32'h0000_00F0, 32'h0000_003C, 4'd0, 64'h30);

    repeat (4) step(1'b0, 32'd0, 4'd0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
